// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: round-robin scanner for a 4:1 channel mux.
// Drives the mux select, waits a settle period, captures the mux output,
// and presents it as a tagged sample on a valid/ready interface.
module mux4_scan_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       chan_mask,
  output logic             sel_s0,
  output logic             sel_s1,
  input  logic [WIDTH-1:0] mux_y,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Counter start value: capture happens when the counter reaches zero,
  // so loading SETTLE_CYC-1 gives SETTLE_CYC cycles of stable select.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [1:0]       chan_nxt;
  logic             valid_nxt;
  logic             frame_nxt;

  // Lowest-numbered enabled channel (0 when the mask is empty).
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Highest-numbered enabled channel; marks the end of a scan frame.
  function automatic logic [1:0] highest_set(input logic [3:0] m);
    highest_set = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) highest_set = 2'(i);
    end
  endfunction

  // Next enabled channel strictly above cur, wrapping to the lowest one.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [3:0] above;
    above = m & (4'b1110 << cur);
    next_set = (above != 4'd0) ? lowest_set(above) : lowest_set(m);
  endfunction

  // Next-state and next-register-value logic for the scan FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    data_nxt  = out_data;
    chan_nxt  = out_chan;
    valid_nxt = out_valid;
    frame_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && (chan_mask != 4'd0)) begin
          sel_nxt   = lowest_set(chan_mask);
          cnt_nxt   = CNT_LOAD;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // en is deliberately ignored: a started sample always completes.
        if (cnt == 4'd0) begin
          data_nxt  = mux_y;
          chan_nxt  = sel;
          valid_nxt = 1'b1;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WAIT: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          // Frame ends when the accepted channel is at or past the top
          // enabled channel of the mask seen on this very edge.
          frame_nxt = (chan_mask != 4'd0) && (sel >= highest_set(chan_mask));
          if (en && (chan_mask != 4'd0)) begin
            sel_nxt   = next_set(chan_mask, sel);
            cnt_nxt   = CNT_LOAD;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 2'd0;
      cnt        <= 4'd0;
      out_data   <= '0;
      out_chan   <= 2'd0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      out_data   <= data_nxt;
      out_chan   <= chan_nxt;
      out_valid  <= valid_nxt;
      frame_done <= frame_nxt;
    end
  end

  assign sel_s1 = sel[1];
  assign sel_s0 = sel[0];
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Testbench for mux4_scan_sequencer: directed scenarios plus randomized
// traffic, checked by a scoreboard against a transaction-level model.
module tb_mux4_scan_sequencer;

  localparam int WIDTH      = 4;
  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [3:0]       chan_mask;
  logic             sel_s0, sel_s1;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;
  logic             busy;

  // The four mux sources; mux_y models the external 4:1 mux.
  logic [WIDTH-1:0] a_val [4];
  assign mux_y = a_val[{sel_s1, sel_s0}];

  mux4_scan_sequencer #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .chan_mask(chan_mask),
    .sel_s0(sel_s0), .sel_s1(sel_s1), .mux_y(mux_y),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]       chan;
    logic [WIDTH-1:0] data;
    int               due;
    bit               seen;
  } exp_t;

  exp_t sb_q[$];

  int         cyc = 0;
  bit         m_active = 1'b0;
  logic [1:0] m_cur = 2'd0;
  int         m_due = 0;
  bit         m_fd_nxt = 1'b0;
  bit         snap_busy, snap_valid, snap_fd;
  logic [1:0] snap_sel;

  function automatic logic [1:0] first_set(input logic [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return 2'(c);
    return 2'd0;
  endfunction

  function automatic logic [1:0] top_set(input logic [3:0] m);
    for (int c = 3; c >= 0; c--) if (m[c]) return 2'(c);
    return 2'd0;
  endfunction

  function automatic logic [1:0] after_chan(input logic [3:0] m, input logic [1:0] cur);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (int'(cur) + k) % 4;
      if (m[c]) return 2'(c);
    end
    return cur;
  endfunction

  task automatic issue();
    m_due    = cyc + SETTLE_CYC + 1;
    m_active = 1'b1;
    sb_q.push_back('{chan: m_cur, data: a_val[m_cur], due: m_due, seen: 1'b0});
  endtask

  // Model: at each falling edge, snapshot what the DUT should show now,
  // then predict what the coming rising edge does from the stable inputs.
  always @(negedge clk) begin
    cyc++;
    snap_busy  = m_active;
    snap_valid = m_active && (cyc >= m_due);
    snap_sel   = m_cur;
    snap_fd    = m_fd_nxt;
    m_fd_nxt   = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      m_active = 1'b0;
      m_cur    = 2'd0;
    end else if (!m_active) begin
      if (en && chan_mask != 4'd0) begin
        m_cur = first_set(chan_mask);
        issue();
      end
    end else if (cyc >= m_due && out_ready) begin
      m_fd_nxt = (chan_mask != 4'd0) && (m_cur >= top_set(chan_mask));
      if (en && chan_mask != 4'd0) begin
        m_cur = after_chan(chan_mask, m_cur);
        issue();
      end else begin
        m_active = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit rst_d = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (!rst_d) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      check("rst_sel", 32'({sel_s1, sel_s0}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
    end
    check("busy", 32'(busy), 32'(snap_busy));
    check("out_valid", 32'(out_valid), 32'(snap_valid));
    check("sel", 32'({sel_s1, sel_s0}), 32'(snap_sel));
    check("frame_done", 32'(frame_done), 32'(snap_fd));
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        check("sample_expected", 32'd0, 32'd1);
      end else begin
        check("out_chan", 32'(out_chan), 32'(sb_q[0].chan));
        check("out_data", 32'(out_data), 32'(sb_q[0].data));
        if (!sb_q[0].seen) begin
          check("capture_latency", 32'(cyc), 32'(sb_q[0].due));
          sb_q[0].seen = 1'b1;
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    rst_d = rst_n;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid_chan(input logic [1:0] ch, input int budget);
    bit found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (out_valid && out_chan == ch) found = 1'b1;
      else step(1);
    end
    check("wait_valid_chan", 32'(found), 32'd1);
  endtask

  task automatic wait_settle_chan(input logic [1:0] ch, input int budget);
    bit found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (busy && !out_valid && {sel_s1, sel_s0} == ch) found = 1'b1;
      else step(1);
    end
    check("wait_settle_chan", 32'(found), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    chan_mask = 4'b1111;
    out_ready = 1'b1;
    a_val[0] = 4'h3; a_val[1] = 4'hA; a_val[2] = 4'h5; a_val[3] = 4'hC;

    // Reset and full scan.
    step(3);
    rst_n = 1'b1;
    step(16);

    // Sparse mask, then mask change while holding a chan-1 sample.
    chan_mask = 4'b1010;
    step(14);
    out_ready = 1'b0;
    wait_valid_chan(2'd1, 20);
    chan_mask = 4'b0100;
    step(2);
    out_ready = 1'b1;
    step(8);

    // Backpressure on chan 2 with the source changing during the stall.
    out_ready = 1'b0;
    wait_valid_chan(2'd2, 20);
    for (int k = 0; k < 10; k++) begin
      a_val[2] = ~a_val[2];
      step(1);
    end
    a_val[2] = 4'h5;
    out_ready = 1'b1;
    step(6);

    // Enable drop during SETTLE of chan 1.
    chan_mask = 4'b0010;
    wait_settle_chan(2'd1, 20);
    en = 1'b0;
    step(10);
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_valid", 32'(out_valid), 32'd0);

    // Reset while a sample is stalled in WAIT.
    en = 1'b1;
    chan_mask = 4'b1111;
    out_ready = 1'b0;
    wait_valid_chan(2'd0, 20);
    rst_n = 1'b0;
    step(1);
    check("midwait_rst_valid", 32'(out_valid), 32'd0);
    check("midwait_rst_data", 32'(out_data), 32'd0);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(5);

    // Randomized traffic; sources are changed only under reset.
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) a_val[c] = 4'($urandom_range(0, 15));
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) chan_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) en = ~en;
      rst_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux4_scan_sequencer.md
Name: mux4_scan_sequencer

Overview:
- Sequencer that sits upstream and downstream of the 4-bit 4:1 channel mux. It drives the mux select lines (s1,s0) and captures the mux output.
- Round-robin scan over a programmable set of enabled channels. Each selected channel gets a settle period, then one sample is taken and presented on a valid/ready interface.
- Turns four parallel 4-bit sources into a tagged, time-multiplexed sample stream.

Parameters:
- WIDTH, 4, data width of the mux output and the sample register.
- SETTLE_CYC, 2, cycles the select is held stable before capture (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable, level-sensitive.
- chan_mask  input  4  bit i=1 enables channel i.
- sel_s0  output  1  mux select LSB.
- sel_s1  output  1  mux select MSB (channel = {sel_s1,sel_s0}).
- mux_y  input  WIDTH  data returned from the mux output.
- out_data  output  WIDTH  captured sample.
- out_chan  output  2  channel index of out_data.
- out_valid  output  1  sample available.
- out_ready  input  1  downstream accepts the sample.
- frame_done  output  1  one-cycle pulse when the last enabled channel of a frame is accepted.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values, all taken on the clk edge with rst_n=0: state=IDLE, sel_s1/sel_s0=0/0, out_data=0, out_chan=0, out_valid=0, frame_done=0, busy=0, settle counter=0. Reset mid-operation aborts everything and drops out_valid on that edge; no pending sample survives.
- FSM has three states: IDLE, SETTLE, WAIT.
- IDLE:
  - If en=1 and chan_mask!=0, load the select with the lowest set bit of chan_mask, load the counter with SETTLE_CYC-1, and go to SETTLE.
  - Otherwise stay in IDLE with the select held at its last value.
- SETTLE:
  - The select is stable throughout. The counter decrements each cycle.
  - In the cycle the counter is 0: out_data<=mux_y, out_chan<=current select, out_valid<=1, go to WAIT.
  - Select-to-capture therefore spans exactly SETTLE_CYC cycles.
  - en is ignored in SETTLE; a started sample always completes.
- WAIT:
  - out_valid, out_data and out_chan are held constant until out_valid && out_ready.
  - On the handshake edge: out_valid<=0.
  - If en=1 and the current chan_mask!=0, the select moves to the next set bit strictly above the current channel, wrapping 3->0 to the lowest set bit. The counter reloads and the FSM goes to SETTLE.
  - Otherwise go to IDLE.
- Mask timing: chan_mask is sampled only at the IDLE exit and at the handshake. Mask changes at other times take effect at the next advance.
- Single enabled channel: the same channel is re-sampled every SETTLE_CYC+1 cycles when out_ready is held at 1.
- frame_done: registered, high in the cycle after a handshake whose accepted channel is >= the highest set bit of chan_mask sampled on that same edge (i.e. the scan wraps). With a single enabled channel it pulses on every accept.
- Throughput: at most one sample per SETTLE_CYC+1 cycles. out_valid is never high on two consecutive accepted cycles.
- en falling while in WAIT: the current sample is still delivered, then the FSM goes to IDLE.
- chan_mask=0 at the handshake: go to IDLE, no frame_done.
- busy: combinational (state != IDLE).

Test Plan:
1. Reset and idle: reset with en=1 and mask=4'b1111, then release. Required: select=00 and out_valid=0 during reset. SETTLE starts on the first cycle after release, and out_valid rises 2 cycles later with out_chan=0.
2. Full scan: mux_y modelled as a 4:1 mux of A0..A3 = 4'h3, 4'hA, 4'h5, 4'hC, with out_ready=1 and SETTLE_CYC=2. Required: samples (chan,data) = (0,3), (1,A), (2,5), (3,C), (0,3) ..., spaced 3 cycles apart. frame_done pulses once after each chan-3 accept.
3. Sparse mask: mask=4'b1010. Required: channel sequence 1,3,1,3 and frame_done only after chan 3. Changing the mask to 4'b0100 while in WAIT on chan 1 makes the next sample chan 2, with frame_done after chan 2.
4. Backpressure: hold out_ready=0 for 10 cycles while sampling chan 2, toggling A2 during the stall. Required: out_valid stays 1 and out_data/out_chan stay frozen at the originally captured value. The select does not advance until out_ready=1.
5. Enable drop: deassert en during SETTLE of chan 1. Required: the chan-1 sample is still produced and accepted, then busy=0 and out_valid stays 0.
6. Reset mid-WAIT: assert rst_n=0 while out_valid=1 and out_ready=0. Required: on the next edge out_valid=0, out_data=0, select=00 and state=IDLE.
